// File: rtl/console_writer.sv
// Character-cell console writer: clears a text buffer, then places characters at a cursor.
// Define CONSOLE_WRITER_SCROLL_EN to scroll on line overflow instead of wrapping to (0,0).
`timescale 1ns/1ps
module console_writer #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 30,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  output logic [11:0] text_addr,
  output logic        text_write,
  output logic [7:0]  text_wdata,
  input  logic [7:0]  text_rdata,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        busy
);

  localparam logic [11:0] CELLS    = 12'(COLS * ROWS);
  localparam logic [11:0] COLS_W   = 12'(COLS);
  localparam logic [6:0]  X_LAST   = 7'(COLS - 1);
  localparam logic [4:0]  Y_LAST   = 5'(ROWS - 1);
`ifdef CONSOLE_WRITER_SCROLL_EN
  localparam logic [11:0] SCR_LAST = 12'((ROWS - 1) * COLS - 1);
  localparam logic [11:0] CLR_BASE = 12'((ROWS - 1) * COLS);
  localparam logic [11:0] CELL_END = 12'(COLS * ROWS - 1);
`endif

  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_CR = 8'h0D;
  localparam logic [7:0] C_BS = 8'h08;

`ifdef CONSOLE_WRITER_SCROLL_EN
  typedef enum logic [2:0] {
    INIT_CLR, IDLE, WRITE, SCR_RD, SCR_WR, SCR_CLR
  } state_t;
`else
  typedef enum logic [2:0] {
    INIT_CLR, IDLE, WRITE
  } state_t;
  logic unused_rdata;
  assign unused_rdata = ^text_rdata;
`endif

  state_t      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [6:0]  cx_q, cx_d;
  logic [4:0]  cy_q, cy_d;
  logic        adv_q, adv_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  logic [11:0] cur_addr;
  logic        printable;
  logic        nl;

  assign cur_addr  = 12'(cy_q) * COLS_W + {5'b0, cx_q};
  assign printable = (char_data >= 8'h20) && (char_data <= 8'h7E);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    adv_d   = adv_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ready_d = 1'b0;
    busy_d  = 1'b1;
    nl      = 1'b0;

    unique case (state_q)
      INIT_CLR: begin
        if (cnt_q == CELLS) begin
          state_d = IDLE;
          cnt_d   = '0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          we_d    = 1'b1;
          addr_d  = cnt_q;
          wdata_d = BLANK;
          cnt_d   = cnt_q + 12'd1;
        end
      end
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (char_valid && ready_q) begin
          unique case (1'b1)
            printable: begin
              state_d = WRITE;
              we_d    = 1'b1;
              addr_d  = cur_addr;
              wdata_d = char_data;
              adv_d   = 1'b1;
              ready_d = 1'b0;
              busy_d  = 1'b1;
            end
            (char_data == C_LF): begin
              cx_d = '0;
              nl   = 1'b1;
            end
            (char_data == C_CR): cx_d = '0;
            (char_data == C_BS): begin
              if (cx_q != '0) begin
                // cursor moves now; WRITE must not advance it again
                cx_d    = cx_q - 7'd1;
                state_d = WRITE;
                we_d    = 1'b1;
                addr_d  = cur_addr - 12'd1;
                wdata_d = BLANK;
                adv_d   = 1'b0;
                ready_d = 1'b0;
                busy_d  = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      WRITE: begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (adv_q) begin
          if (cx_q == X_LAST) begin
            cx_d = '0;
            nl   = 1'b1;
          end else begin
            cx_d = cx_q + 7'd1;
          end
        end
      end
`ifdef CONSOLE_WRITER_SCROLL_EN
      SCR_RD: begin
        state_d = SCR_WR;
        we_d    = 1'b1;
        addr_d  = cnt_q;
        wdata_d = text_rdata;
      end
      SCR_WR: begin
        if (cnt_q == SCR_LAST) begin
          state_d = SCR_CLR;
          cnt_d   = '0;
          we_d    = 1'b1;
          addr_d  = CLR_BASE;
          wdata_d = BLANK;
        end else begin
          state_d = SCR_RD;
          cnt_d   = cnt_q + 12'd1;
          addr_d  = cnt_q + 12'd1 + COLS_W;
        end
      end
      SCR_CLR: begin
        if (addr_q == CELL_END) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          we_d    = 1'b1;
          addr_d  = addr_q + 12'd1;
          wdata_d = BLANK;
        end
      end
`endif
      default: ;
    endcase

    if (nl) begin
      if (cy_q == Y_LAST) begin
`ifdef CONSOLE_WRITER_SCROLL_EN
        state_d = SCR_RD;
        cnt_d   = '0;
        we_d    = 1'b0;
        addr_d  = COLS_W;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        cx_d    = '0;
        cy_d    = Y_LAST;
`else
        cx_d = '0;
        cy_d = '0;
`endif
      end else begin
        cy_d = cy_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT_CLR;
      cnt_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      adv_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= BLANK;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      adv_q   <= adv_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign char_ready = ready_q;
  assign text_addr  = addr_q;
  assign text_write = we_q;
  assign text_wdata = wdata_q;
  assign cursor_x   = cx_q;
  assign cursor_y   = cy_q;
  assign busy       = busy_q;

endmodule
